// File: rtl/power_est_pkg.sv
// Shared definitions for the write-back energy estimator: retire classes, the
// class weight table and the closed-window result record.
package power_est_pkg;

  typedef enum logic [2:0] {
    CLS_RR_ALU = 3'b000,
    CLS_RM_ALU = 3'b001,
    CLS_LOAD   = 3'b010,
    CLS_STORE  = 3'b011,
    CLS_BRANCH = 3'b100,
    CLS_HALT   = 3'b101
  } ret_class_e;

  localparam logic [5:0] OP_MUL = 6'b000101;

  // One sampling edge contributes at most 12 + 32, so 8 bits are plenty.
  localparam int CONTRIB_W = 8;

  localparam logic [CONTRIB_W-1:0] W_ALU    = 8'd4;
  localparam logic [CONTRIB_W-1:0] W_MUL    = 8'd12;
  localparam logic [CONTRIB_W-1:0] W_LOAD   = 8'd10;
  localparam logic [CONTRIB_W-1:0] W_STORE  = 8'd9;
  localparam logic [CONTRIB_W-1:0] W_BRANCH = 8'd3;

  localparam int RES_DATA_W = 32;
  localparam int RES_CNT_W  = 32;

  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic [RES_CNT_W-1:0]  count;
    logic                  last;
  } est_result_t;

  function automatic logic [CONTRIB_W-1:0] class_weight(input logic [2:0] cls,
                                                       input logic [5:0] op);
    logic [CONTRIB_W-1:0] w;
    w = '0;
    case (cls)
      CLS_RR_ALU: w = (op == OP_MUL) ? W_MUL : W_ALU;
      CLS_RM_ALU: w = W_ALU;
      CLS_LOAD:   w = W_LOAD;
      CLS_STORE:  w = W_STORE;
      CLS_BRANCH: w = W_BRANCH;
      default:    w = '0;
    endcase
    return w;
  endfunction

  function automatic logic writes_reg(input logic [2:0] cls);
    return (cls == CLS_RR_ALU) || (cls == CLS_RM_ALU) || (cls == CLS_LOAD);
  endfunction

endpackage

// File: rtl/popcount32.sv
// Number of set bits in a 32-bit word; used for write-back toggle counting.
module popcount32 (
  input  logic [31:0] a_i,
  output logic [5:0]  cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_o = cnt_o + {5'd0, a_i[i]};
    end
  end

endmodule

// File: rtl/power_window_estimator.sv
// Windowed dynamic-energy estimate of retired instructions. Stage 1 forms the
// per-edge contribution, stage 2 accumulates and loads the result register.
module power_window_estimator
  import power_est_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 16,
  parameter int IDLE_W = 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             ret_valid,
  input  logic [2:0]       ret_type,
  input  logic [5:0]       ret_opcode,
  input  logic [31:0]      ret_wdata,
  input  logic             halted,
  output logic             est_valid,
  input  logic             est_ready,
  output logic [ACC_W-1:0] est_data,
  output logic [CNT_W-1:0] est_count,
  output logic             est_last,
  output logic             est_overrun,
  input  logic             est_overrun_clr
);

  localparam int WIN_CW = $clog2(WINDOW);
  localparam int AEW    = ACC_W + 1;

  logic                 halted_q;
  logic [31:0]          prev_wd_q, prev_wd_d;
  logic [WIN_CW-1:0]    win_q, win_d;
  logic [CONTRIB_W-1:0] s1_contrib_q, s1_contrib_d;
  logic                 s1_ret_q, s1_ret_d;
  logic                 s1_close_q, s1_close_d;
  logic                 s1_last_q, s1_last_d;
  logic [5:0]           toggle;

  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
  logic [AEW-1:0]       acc_ext;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_sum;
  est_result_t          res_q, res_d;
  logic                 vld_q, vld_d;
  logic                 ovr_q, ovr_d;

  popcount32 u_popcount (
    .a_i   (ret_wdata ^ prev_wd_q),
    .cnt_o (toggle)
  );

  // The edge on which halted first reads 1 is not sampled; it only closes a
  // partial window, and only if that window has at least one sampled edge.
  always_comb begin
    prev_wd_d    = prev_wd_q;
    win_d        = win_q;
    s1_contrib_d = '0;
    s1_ret_d     = 1'b0;
    s1_close_d   = 1'b0;
    s1_last_d    = 1'b0;
    if (halted) begin
      win_d = '0;
      if (!halted_q && (win_q != '0)) begin
        s1_close_d = 1'b1;
        s1_last_d  = 1'b1;
      end
    end else begin
      if (ret_valid) begin
        s1_ret_d     = 1'b1;
        s1_contrib_d = class_weight(ret_type, ret_opcode);
        if (writes_reg(ret_type)) begin
          s1_contrib_d = s1_contrib_d + CONTRIB_W'(toggle);
          prev_wd_d    = ret_wdata;
        end
      end else begin
        s1_contrib_d = CONTRIB_W'(IDLE_W);
      end
      if (win_q == WIN_CW'(WINDOW - 1)) begin
        s1_close_d = 1'b1;
        win_d      = '0;
      end else begin
        win_d = win_q + WIN_CW'(1);
      end
    end
  end

  assign acc_ext = {1'b0, acc_q} + AEW'(s1_contrib_q);
  assign acc_sum = acc_ext[ACC_W] ? '1 : acc_ext[ACC_W-1:0];
  assign cnt_sum = (s1_ret_q && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  // Result port: a result is transferred on any edge with est_valid & est_ready;
  // est_valid then drops unless a new window closes on that same edge.
  always_comb begin
    acc_d = acc_sum;
    cnt_d = cnt_sum;
    res_d = res_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (vld_q && est_ready) vld_d = 1'b0;
    if (est_overrun_clr)    ovr_d = 1'b0;
    if (s1_close_q) begin
      acc_d       = '0;
      cnt_d       = '0;
      res_d.data  = RES_DATA_W'(acc_sum);
      res_d.count = RES_CNT_W'(cnt_sum);
      res_d.last  = s1_last_q;
      vld_d       = 1'b1;
      if (vld_q && !est_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      halted_q     <= 1'b0;
      prev_wd_q    <= '0;
      win_q        <= '0;
      s1_contrib_q <= '0;
      s1_ret_q     <= 1'b0;
      s1_close_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      vld_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      halted_q     <= halted;
      prev_wd_q    <= prev_wd_d;
      win_q        <= win_d;
      s1_contrib_q <= s1_contrib_d;
      s1_ret_q     <= s1_ret_d;
      s1_close_q   <= s1_close_d;
      s1_last_q    <= s1_last_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      vld_q        <= vld_d;
      ovr_q        <= ovr_d;
    end
  end

  assign est_valid   = vld_q;
  assign est_data    = res_q.data[ACC_W-1:0];
  assign est_count   = res_q.count[CNT_W-1:0];
  assign est_last    = res_q.last;
  assign est_overrun = ovr_q;

endmodule

// File: tb/tb_power_window_estimator.sv
// Bench for power_window_estimator: two instances (WINDOW=4/ACC_W=24 and
// WINDOW=32/ACC_W=8) share stimulus and are checked against a window-sum model.
module tb_power_window_estimator;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ret_valid = 1'b0;
  logic [2:0]  ret_type = '0;
  logic [5:0]  ret_opcode = '0;
  logic [31:0] ret_wdata = '0;
  logic        halted = 1'b0;
  logic        est_ready = 1'b1;
  logic        est_overrun_clr = 1'b0;

  logic        v_a, l_a, o_a;
  logic [23:0] d_a;
  logic [15:0] c_a;
  logic        v_s, l_s, o_s;
  logic [7:0]  d_s;
  logic [15:0] c_s;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_MUL = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  // clock / reset
  always #5 clk1 = ~clk1;

  power_window_estimator #(.WINDOW(4), .ACC_W(24), .CNT_W(16), .IDLE_W(1)) dut (
    .clk1(clk1), .rst_n(rst_n), .ret_valid(ret_valid), .ret_type(ret_type),
    .ret_opcode(ret_opcode), .ret_wdata(ret_wdata), .halted(halted),
    .est_valid(v_a), .est_ready(est_ready), .est_data(d_a), .est_count(c_a),
    .est_last(l_a), .est_overrun(o_a), .est_overrun_clr(est_overrun_clr)
  );

  power_window_estimator #(.WINDOW(32), .ACC_W(8), .CNT_W(16), .IDLE_W(1)) dut_s (
    .clk1(clk1), .rst_n(rst_n), .ret_valid(ret_valid), .ret_type(ret_type),
    .ret_opcode(ret_opcode), .ret_wdata(ret_wdata), .halted(halted),
    .est_valid(v_s), .est_ready(est_ready), .est_data(d_s), .est_count(c_s),
    .est_last(l_s), .est_overrun(o_s), .est_overrun_clr(est_overrun_clr)
  );

  // reference model: per-window energy sum plus the held result and overrun
  typedef struct {
    bit          hp;
    logic [31:0] prev;
    int          n;
    longint      en;
    int          cnt;
    bit          pend;
    longint      pd;
    int          pc;
    bit          pl;
    bit          rv;
    bit          ovr;
  } mdl_t;

  mdl_t m [2];
  logic [48:0] exp_q0[$];
  logic [48:0] exp_q1[$];

  function automatic int weight_of(logic [2:0] t, logic [5:0] op);
    case (t)
      3'd0:    return (op == OP_MUL) ? 12 : 4;
      3'd1:    return 4;
      3'd2:    return 10;
      3'd3:    return 9;
      3'd4:    return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].hp = 0; m[i].prev = '0; m[i].n = 0; m[i].en = 0; m[i].cnt = 0;
      m[i].pend = 0; m[i].pd = 0; m[i].pc = 0; m[i].pl = 0; m[i].rv = 0; m[i].ovr = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_close(input int i, input bit last);
    longint amax;
    amax = (i == 0) ? 64'd16777215 : 64'd255;
    m[i].pend = 1;
    m[i].pd   = (m[i].en > amax) ? amax : m[i].en;
    m[i].pc   = (m[i].cnt > 65535) ? 65535 : m[i].cnt;
    m[i].pl   = last;
    m[i].en = 0; m[i].cnt = 0; m[i].n = 0;
  endtask

  task automatic model_edge(input int i);
    int  w;
    bit  set_ovr;
    logic [48:0] rec;
    w = (i == 0) ? 4 : 32;
    set_ovr = 0;
    if (m[i].pend) begin
      rec = {m[i].pl, 16'(m[i].pc), 32'(m[i].pd)};
      if (m[i].rv && !est_ready) begin
        set_ovr = 1;
        if (i == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
      end
      if (i == 0) exp_q0.push_back(rec); else exp_q1.push_back(rec);
      m[i].rv = 1;
      m[i].pend = 0;
    end else if (m[i].rv && est_ready) begin
      m[i].rv = 0;
    end
    if (set_ovr) m[i].ovr = 1;
    else if (est_overrun_clr) m[i].ovr = 0;
    if (halted) begin
      if (!m[i].hp && m[i].n > 0) model_close(i, 1);
      m[i].hp = 1;
    end else begin
      m[i].hp = 0;
      if (ret_valid) begin
        m[i].en += weight_of(ret_type, ret_opcode);
        m[i].cnt++;
        if (ret_type <= 3'd2) begin
          m[i].en += $countones(ret_wdata ^ m[i].prev);
          m[i].prev = ret_wdata;
        end
      end else begin
        m[i].en += 1;
      end
      m[i].n++;
      if (m[i].n == w) model_close(i, 0);
    end
  endtask

  // scoreboard: an accepted result must equal the oldest expected record
  task automatic chk_result(input int i, input logic [31:0] d, input logic [15:0] c,
                            input logic l);
    logic [48:0] e;
    int sz;
    sz = (i == 0) ? exp_q0.size() : exp_q1.size();
    chk($sformatf("res%0d_queue_nonempty", i), 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("res%0d_data", i), 64'(d), 64'(e[31:0]));
      chk($sformatf("res%0d_count", i), 64'(c), 64'(e[47:32]));
      chk($sformatf("res%0d_last", i), 64'(l), 64'(e[48]));
    end
  endtask

  task automatic tick();
    if (est_ready) begin
      if (v_a) chk_result(0, 32'(d_a), c_a, l_a);
      if (v_s) chk_result(1, 32'(d_s), c_s, l_s);
    end
    model_edge(0);
    model_edge(1);
    @(posedge clk1);
    #1;
    chk("valid_a", 64'(v_a), 64'(m[0].rv));
    chk("overrun_a", 64'(o_a), 64'(m[0].ovr));
    chk("valid_s", 64'(v_s), 64'(m[1].rv));
    chk("overrun_s", 64'(o_s), 64'(m[1].ovr));
  endtask

  // driver tasks
  task automatic ret(input logic [2:0] t, input logic [5:0] op, input logic [31:0] wd);
    ret_valid = 1'b1; ret_type = t; ret_opcode = op; ret_wdata = wd;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic idle();
    ret_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    halted = 1'b0; est_overrun_clr = 1'b0; ret_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("rst_valid", 64'(v_a | v_s), 64'd0);
    chk("rst_data", 64'({d_a, d_s}), 64'd0);
    chk("rst_count", 64'({c_a, c_s}), 64'd0);
    chk("rst_last_ovr", 64'({l_a, l_s, o_a, o_s}), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("init_valid", 64'(v_a | v_s), 64'd0);
    chk("init_data", 64'({d_a, d_s}), 64'd0);
    chk("init_ovr", 64'({o_a, o_s}), 64'd0);
    rst_n = 1'b1;

    // four ADDs, then an idle window, then MUL/LW/SW/BEQZ
    ret(3'd0, OP_ADD, 32'h0);
    ret(3'd0, OP_ADD, 32'hF);
    ret(3'd0, OP_ADD, 32'hF);
    ret(3'd0, OP_ADD, 32'h0);
    idle();
    chk("add_win_data", 64'(d_a), 64'd24);
    chk("add_win_count", 64'(c_a), 64'd4);
    chk("add_win_last", 64'({v_a, l_a}), 64'b10);
    idle(); idle(); idle();
    ret(3'd0, OP_MUL, 32'h0);
    chk("idle_win_data", 64'(d_a), 64'd4);
    chk("idle_win_count", 64'(c_a), 64'd0);
    ret(3'd2, OP_LW, 32'h0);
    ret(3'd3, 6'b101011, 32'h0);
    ret(3'd4, 6'b000100, 32'h0);
    idle();
    chk("mix_win_data", 64'(d_a), 64'd34);
    chk("mix_win_count", 64'(c_a), 64'd4);

    // overrun, clear, and close coinciding with a handshake
    do_reset();
    est_ready = 1'b0;
    idle(); idle(); idle(); idle();
    ret(3'd2, OP_LW, 32'h1);
    idle(); idle(); idle();
    idle();
    chk("ovr_data", 64'(d_a), 64'd14);
    chk("ovr_set", 64'({v_a, o_a}), 64'b11);
    est_overrun_clr = 1'b1;
    idle();
    est_overrun_clr = 1'b0;
    chk("ovr_cleared", 64'(o_a), 64'd0);
    idle(); idle();
    est_ready = 1'b1;
    idle();
    chk("hs_close_valid", 64'(v_a), 64'd1);
    chk("hs_close_data", 64'(d_a), 64'd4);
    chk("hs_close_ovr", 64'(o_a), 64'd0);

    // halt closes a partial window
    do_reset();
    ret(3'd2, OP_LW, 32'hFF);
    idle();
    halted = 1'b1;
    idle();
    idle();
    chk("halt_data", 64'(d_a), 64'd19);
    chk("halt_count", 64'(c_a), 64'd1);
    chk("halt_last", 64'({v_a, l_a}), 64'b11);
    for (int k = 0; k < 4; k++) ret(3'd0, OP_ADD, $urandom);
    chk("halt_quiet", 64'(v_a), 64'd0);
    halted = 1'b0;
    for (int k = 0; k < 4; k++) ret(3'd0, OP_ADD, 32'hFF);
    idle();
    chk("post_halt_data", 64'(d_a), 64'd16);
    chk("post_halt_last", 64'({v_a, l_a}), 64'b10);

    // reset in mid-window
    do_reset();
    ret(3'd0, OP_ADD, 32'hF0);
    ret(3'd0, OP_ADD, 32'h0F);
    do_reset();
    for (int k = 0; k < 4; k++) ret(3'd0, OP_ADD, 32'h0);
    idle();
    chk("post_rst_data", 64'(d_a), 64'd16);
    chk("post_rst_count", 64'(c_a), 64'd4);

    // accumulator saturation on the 8-bit instance
    do_reset();
    for (int k = 0; k < 32; k++) ret(3'd0, OP_MUL, (k % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF);
    idle();
    chk("sat_data", 64'(d_s), 64'd255);
    chk("sat_count", 64'(c_s), 64'd32);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ret_valid       = ($urandom_range(0, 3) != 0);
      ret_type        = 3'($urandom_range(0, 7));
      ret_opcode      = ($urandom_range(0, 3) == 0) ? OP_MUL : 6'($urandom);
      ret_wdata       = $urandom;
      est_ready       = ($urandom_range(0, 2) != 0);
      est_overrun_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) halted = ~halted;
      tick();
    end
    halted = 1'b0; est_ready = 1'b1; est_overrun_clr = 1'b0; ret_valid = 1'b0;
    for (int k = 0; k < 40; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
